cl_line_capture: RTL and testbench

- Parametrised Camera Link line-capture front end; next generation of the 2-tap binarising capture block.
- Accepts TAPS pixels per clock. Per line it builds a threshold-binarised bitmap and PLANES MSB bit-planes in line registers.
- Commits each completed line with a one-cycle write pulse to ping-pong row memories (A/B chosen by iMEM_SEL).
- New behaviour over the previous block: line buffers clear at line start, write pulses only at commit, explicit overflow/frame-done reporting.

---
 rtl/cl_line_capture.sv | 243 ++++++++++++++++++++++++
 tb/tb_cl_line_capture.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_line_capture.sv
// Camera Link line capture: binarises TAPS pixels per clock into a line
// register, extracts MSB bit-planes and commits each line to ping-pong rows.
module cl_line_capture #(
    parameter int TAPS        = 2,
    parameter int PIXEL_WIDTH = 8,
    parameter int LINE_PIXELS = 640,
    parameter int ADDR_WIDTH  = 11,
    parameter int PLANES      = 5
) (
    input  logic                          CCLK,
    input  logic                          RST_N,
    input  logic                          iFVAL,
    input  logic                          iLVAL,
    input  logic                          iDVAL,
    input  logic [TAPS*PIXEL_WIDTH-1:0]   iDATA,
    input  logic [PIXEL_WIDTH-1:0]        iTHRESHOLD,
    input  logic                          iMEM_SEL,
    output logic [LINE_PIXELS-1:0]        oBIN,
    output logic [PLANES*LINE_PIXELS-1:0] oPLANES,
    output logic [ADDR_WIDTH-1:0]         oROW,
    output logic [ADDR_WIDTH-1:0]         oLINE_LEN,
    output logic                          oWEA,
    output logic                          oWEB,
    output logic                          oLINE_VALID,
    output logic                          oFRAME_DONE,
    output logic                          oOVERFLOW
);

    localparam int CW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] TAPS_C = ADDR_WIDTH'(TAPS);
    localparam logic [ADDR_WIDTH:0] TAPS_W = (ADDR_WIDTH+1)'(TAPS);
    localparam logic [ADDR_WIDTH:0] LP_W = (ADDR_WIDTH+1)'(LINE_PIXELS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        CAPTURE,
        COMMIT,
        DONE
    } state_t;

    state_t state, state_n;

    logic                   fval_q;
    logic                   end_frame;
    logic                   ovf_q;
    logic [ADDR_WIDTH-1:0]  col, col_n;
    logic [ADDR_WIDTH-1:0]  row, row_n;
    logic [LINE_PIXELS-1:0] bin_q;
    logic [LINE_PIXELS-1:0] plane_q [PLANES];

    logic                  rise;
    logic                  word_ok;
    logic [ADDR_WIDTH:0]   col_sum;
    logic [ADDR_WIDTH-1:0] col_inc;
    logic                  word_beyond;
    logic [ADDR_WIDTH-1:0] row_inc;
    logic                  row_full;

    logic                  clr;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] base;
    logic                  commit;
    logic                  done;
    logic                  ovf_clr;
    logic                  ovf_set;
    logic [ADDR_WIDTH:0]   pos [TAPS];

    assign rise        = iFVAL & ~fval_q;
    assign word_ok     = iLVAL & iDVAL;
    assign col_sum     = {1'b0, col} + TAPS_W;
    assign col_inc     = (col_sum > {1'b0, CNT_MAX}) ? CNT_MAX
                                                     : col_sum[ADDR_WIDTH-1:0];
    assign word_beyond = col_sum > LP_W;
    assign row_full    = (row == CNT_MAX);
    assign row_inc     = row_full ? CNT_MAX : row + 1'b1;

    // State register and previous-FVAL sample for edge detection
    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            fval_q <= 1'b0;
        end else begin
            state  <= state_n;
            fval_q <= iFVAL;
        end
    end

    // Next-state logic and per-cycle datapath controls
    always_comb begin
        state_n = state;
        clr     = 1'b0;
        wr      = 1'b0;
        base    = '0;
        col_n   = col;
        row_n   = row;
        commit  = 1'b0;
        done    = 1'b0;
        ovf_clr = 1'b0;
        ovf_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_n = WAIT_LINE;
                    row_n   = '0;
                    ovf_clr = 1'b1;
                end
            end
            WAIT_LINE: begin
                if (rise) begin
                    row_n   = '0;
                    ovf_clr = 1'b1;
                end else if (!iFVAL) begin
                    state_n = DONE;
                    done    = 1'b1;
                end else if (word_ok) begin
                    state_n = CAPTURE;
                    clr     = 1'b1;
                    wr      = 1'b1;
                    col_n   = TAPS_C;
                end
            end
            CAPTURE: begin
                if (rise) begin
                    state_n = WAIT_LINE;
                    row_n   = '0;
                    ovf_clr = 1'b1;
                end else if (!iFVAL || !word_ok) begin
                    state_n = COMMIT;
                    commit  = 1'b1;
                end else begin
                    wr      = 1'b1;
                    base    = col;
                    col_n   = col_inc;
                    ovf_set = word_beyond;
                end
            end
            COMMIT: begin
                row_n   = row_inc;
                ovf_set = row_full;
                if (end_frame) begin
                    state_n = DONE;
                    done    = 1'b1;
                end else begin
                    state_n = WAIT_LINE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Column position of each tap in the incoming word
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            pos[k] = {1'b0, base} + (ADDR_WIDTH+1)'(k);
        end
    end

    // Column/row counters, sticky overflow and frame-end flag
    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            col       <= '0;
            row       <= '0;
            ovf_q     <= 1'b0;
            end_frame <= 1'b0;
        end else begin
            col <= col_n;
            row <= row_n;
            if (ovf_clr) begin
                ovf_q <= 1'b0;
            end else if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            if (commit) begin
                end_frame <= ~iFVAL;
            end
        end
    end

    // Line registers: cleared at line start, write of the first word wins
    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            bin_q <= '0;
            for (int p = 0; p < PLANES; p++) begin
                plane_q[p] <= '0;
            end
        end else begin
            if (clr) begin
                bin_q <= '0;
                for (int p = 0; p < PLANES; p++) begin
                    plane_q[p] <= '0;
                end
            end
            if (wr) begin
                for (int k = 0; k < TAPS; k++) begin
                    if (pos[k] < LP_W) begin
                        bin_q[pos[k][CW-1:0]] <=
                            iDATA[k*PIXEL_WIDTH +: PIXEL_WIDTH] > iTHRESHOLD;
                        for (int p = 0; p < PLANES; p++) begin
                            plane_q[p][pos[k][CW-1:0]] <=
                                iDATA[k*PIXEL_WIDTH + PIXEL_WIDTH - 1 - p];
                        end
                    end
                end
            end
        end
    end

    // Commit and frame-done strobes with held row/length
    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            oLINE_VALID <= 1'b0;
            oWEA        <= 1'b0;
            oWEB        <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oROW        <= '0;
            oLINE_LEN   <= '0;
        end else begin
            oLINE_VALID <= commit;
            oWEA        <= commit & ~iMEM_SEL;
            oWEB        <= commit & iMEM_SEL;
            oFRAME_DONE <= done;
            if (commit) begin
                oROW      <= row;
                oLINE_LEN <= col;
            end
        end
    end

    assign oBIN      = bin_q;
    assign oOVERFLOW = ovf_q;

    for (genvar p = 0; p < PLANES; p++) begin : g_plane
        assign oPLANES[p*LINE_PIXELS +: LINE_PIXELS] = plane_q[p];
    end

endmodule

// File: tb/tb_cl_line_capture.sv
// Bench for cl_line_capture: two configurations driven in lockstep,
// checked against a per-line pixel-queue model.
module tb_cl_line_capture;

    localparam int T1 = 2, LP1 = 640, AW1 = 11, PL1 = 5;
    localparam int T2 = 4, LP2 = 16, AW2 = 5, PL2 = 3;

    typedef logic [639:0] w_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fval = 1'b0, lval = 1'b0, dval = 1'b0, msel = 1'b0;
    logic [7:0] thr = 8'd0;
    logic [T1*8-1:0] d1 = '0;
    logic [T2*8-1:0] d2 = '0;

    logic [LP1-1:0]     bin1;
    logic [PL1*LP1-1:0] planes1;
    logic [AW1-1:0]     row1, len1;
    logic wea1, web1, lv1, fd1, ovf1;
    logic [LP2-1:0]     bin2;
    logic [PL2*LP2-1:0] planes2;
    logic [AW2-1:0]     row2, len2;
    logic wea2, web2, lv2, fd2, ovf2;

    cl_line_capture #(.TAPS(T1), .PIXEL_WIDTH(8), .LINE_PIXELS(LP1),
                      .ADDR_WIDTH(AW1), .PLANES(PL1)) u_dut1 (
        .CCLK(clk), .RST_N(rst_n), .iFVAL(fval), .iLVAL(lval),
        .iDVAL(dval), .iDATA(d1), .iTHRESHOLD(thr), .iMEM_SEL(msel),
        .oBIN(bin1), .oPLANES(planes1), .oROW(row1), .oLINE_LEN(len1),
        .oWEA(wea1), .oWEB(web1), .oLINE_VALID(lv1),
        .oFRAME_DONE(fd1), .oOVERFLOW(ovf1));

    cl_line_capture #(.TAPS(T2), .PIXEL_WIDTH(8), .LINE_PIXELS(LP2),
                      .ADDR_WIDTH(AW2), .PLANES(PL2)) u_dut2 (
        .CCLK(clk), .RST_N(rst_n), .iFVAL(fval), .iLVAL(lval),
        .iDVAL(dval), .iDATA(d2), .iTHRESHOLD(thr), .iMEM_SEL(msel),
        .oBIN(bin2), .oPLANES(planes2), .oROW(row2), .oLINE_LEN(len2),
        .oWEA(wea2), .oWEB(web2), .oLINE_VALID(lv2),
        .oFRAME_DONE(fd2), .oOVERFLOW(ovf2));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int q1[$], q2[$];
    int line_no = 0;
    bit m_ovf1 = 0, m_ovf2 = 0;
    int ewa1 = 0, ewb1 = 0, ewa2 = 0, ewb2 = 0;
    int mwa1 = 0, mwb1 = 0, mwa2 = 0, mwb2 = 0, both = 0;

    task automatic check(input string tag, input w_t got, input w_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // strobe pulse counters, one count per high cycle
    always @(negedge clk) begin
        if (rst_n) begin
            mwa1 <= mwa1 + int'(wea1);
            mwb1 <= mwb1 + int'(web1);
            mwa2 <= mwa2 + int'(wea2);
            mwb2 <= mwb2 + int'(web2);
            both <= both + int'(wea1 & web1) + int'(wea2 & web2);
        end
    end

    function automatic int sat(input int v, input int aw);
        int m = (1 << aw) - 1;
        return (v > m) ? m : v;
    endfunction

    // expected line register: pl < 0 gives the bitmap, else plane pl
    function automatic w_t exp_row(input int q[$], input int lp,
                                   input int pl);
        w_t r = '0;
        int v;
        for (int x = 0; x < q.size() && x < lp; x++) begin
            v = q[x];
            if (pl < 0) r[x] = (v > int'(thr));
            else        r[x] = v[7-pl];
        end
        return r;
    endfunction

    function automatic int pix(input int mode, input int x, input int k,
                               input bit second);
        case (mode)
            0:       return int'($urandom_range(0, 255));
            1:       return second ? (x % 256) : ((k == 0) ? 100 : 101);
            2:       return 0;
            default: return 'hA8;
        endcase
    endfunction

    task automatic drive_words(input int nw, input int mode);
        int v;
        q1.delete();
        q2.delete();
        for (int w = 0; w < nw; w++) begin
            @(negedge clk);
            lval = 1'b1;
            dval = 1'b1;
            for (int k = 0; k < T1; k++) begin
                v = pix(mode, w*T1 + k, k, 1'b0);
                d1[k*8 +: 8] = 8'(v);
                q1.push_back(v);
            end
            for (int k = 0; k < T2; k++) begin
                v = pix(mode, w*T2 + k, k, 1'b1);
                d2[k*8 +: 8] = 8'(v);
                q2.push_back(v);
            end
        end
    endtask

    task automatic finish_line(input bit sel, input bit last);
        @(negedge clk);
        lval = 1'b0;
        dval = 1'b0;
        msel = sel;
        if (last) fval = 1'b0;
        @(negedge clk);
        check("lv1", w_t'(lv1), w_t'(1'b1));
        check("wea1", w_t'(wea1), w_t'(!sel));
        check("web1", w_t'(web1), w_t'(sel));
        check("row1", w_t'(row1), w_t'(sat(line_no, AW1)));
        check("len1", w_t'(len1), w_t'(sat(q1.size(), AW1)));
        check("bin1", w_t'(bin1), exp_row(q1, LP1, -1));
        for (int p = 0; p < PL1; p++)
            check("plane1", w_t'(planes1[p*LP1 +: LP1]), exp_row(q1, LP1, p));
        check("fd1", w_t'(fd1), w_t'(1'b0));
        check("lv2", w_t'(lv2), w_t'(1'b1));
        check("wea2", w_t'(wea2), w_t'(!sel));
        check("web2", w_t'(web2), w_t'(sel));
        check("row2", w_t'(row2), w_t'(sat(line_no, AW2)));
        check("len2", w_t'(len2), w_t'(sat(q2.size(), AW2)));
        check("bin2", w_t'(bin2), exp_row(q2, LP2, -1));
        for (int p = 0; p < PL2; p++)
            check("plane2", w_t'(planes2[p*LP2 +: LP2]), exp_row(q2, LP2, p));
        check("fd2", w_t'(fd2), w_t'(1'b0));
        m_ovf1 = m_ovf1 | (q1.size() > LP1) | (line_no >= (1 << AW1) - 1);
        m_ovf2 = m_ovf2 | (q2.size() > LP2) | (line_no >= (1 << AW2) - 1);
        if (sel) begin ewb1++; ewb2++; end
        else     begin ewa1++; ewa2++; end
        line_no++;
        @(negedge clk);
        check("lv1_off", w_t'(lv1), w_t'(1'b0));
        check("lv2_off", w_t'(lv2), w_t'(1'b0));
        check("ovf1", w_t'(ovf1), w_t'(m_ovf1));
        check("ovf2", w_t'(ovf2), w_t'(m_ovf2));
        check("fd1_end", w_t'(fd1), w_t'(last));
        check("fd2_end", w_t'(fd2), w_t'(last));
        if (last) begin
            @(negedge clk);
            check("fd1_off", w_t'(fd1), w_t'(1'b0));
            check("fd2_off", w_t'(fd2), w_t'(1'b0));
        end
    endtask

    task automatic do_line(input int nw, input int mode, input bit sel,
                           input bit last);
        drive_words(nw, mode);
        finish_line(sel, last);
    endtask

    task automatic frame_start();
        @(negedge clk);
        fval = 1'b1;
        lval = 1'b0;
        dval = 1'b0;
        line_no = 0;
        m_ovf1 = 0;
        m_ovf2 = 0;
        @(negedge clk);
        check("ovf1_clr", w_t'(ovf1), w_t'(1'b0));
        check("ovf2_clr", w_t'(ovf2), w_t'(1'b0));
    endtask

    task automatic end_frame();
        @(negedge clk);
        fval = 1'b0;
        @(negedge clk);
        check("fd1_wl", w_t'(fd1), w_t'(1'b1));
        check("fd2_wl", w_t'(fd2), w_t'(1'b1));
        check("lv1_wl", w_t'(lv1), w_t'(1'b0));
        @(negedge clk);
        check("fd1_wl_off", w_t'(fd1), w_t'(1'b0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bin1"}, w_t'(bin1), '0);
        for (int p = 0; p < PL1; p++)
            check({tag, "_pl1"}, w_t'(planes1[p*LP1 +: LP1]), '0);
        check({tag, "_row1"}, w_t'(row1), '0);
        check({tag, "_len1"}, w_t'(len1), '0);
        check({tag, "_str1"}, w_t'({wea1, web1, lv1, fd1, ovf1}), '0);
        check({tag, "_bin2"}, w_t'(bin2), '0);
        check({tag, "_pl2"}, w_t'(planes2), '0);
        check({tag, "_len2"}, w_t'(len2), '0);
        check({tag, "_str2"}, w_t'({wea2, web2, lv2, fd2, ovf2}), '0);
    endtask

    initial begin
        int nl;
        int nw;
        repeat (2) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;

        // alternating 100/101 pixels against threshold 100
        thr = 8'd100;
        frame_start();
        do_line(320, 1, 1'b0, 1'b1);
        check("bin_alt", w_t'(bin1), w_t'({320{2'b10}}));
        check("len_640", w_t'(len1), w_t'(640));

        // three lines, ping-pong select, last line all zero
        thr = 8'($urandom_range(0, 255));
        frame_start();
        do_line(320, 0, 1'b1, 1'b0);
        do_line(320, 0, 1'b1, 1'b0);
        do_line(320, 2, 1'b0, 1'b0);
        check("bin_zero", w_t'(bin1), '0);
        end_frame();

        // overflowing line, then FVAL cut after 10 words
        frame_start();
        do_line(321, 0, 1'b0, 1'b1);
        check("ovf_642", w_t'(len1), w_t'(642));
        frame_start();
        do_line(10, 0, 1'b1, 1'b1);

        // 0xA8 plane pattern, then reset in the middle of a line
        frame_start();
        do_line(4, 3, 1'b0, 1'b0);
        check("plane_a8", w_t'({planes1[4*LP1], planes1[3*LP1],
                                planes1[2*LP1], planes1[LP1],
                                planes1[0]}), w_t'(5'b10101));
        drive_words(5, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        fval = 1'b0;
        lval = 1'b0;
        dval = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 4-tap ramp 0..15 against threshold 7
        thr = 8'd7;
        frame_start();
        do_line(4, 1, 1'b0, 1'b1);
        check("bin_ff00", w_t'(bin2), w_t'(16'hFF00));
        check("len_16", w_t'(len2), w_t'(16));

        // long frame: row counter of the narrow instance saturates
        thr = 8'($urandom_range(0, 255));
        frame_start();
        for (int i = 0; i < 34; i++)
            do_line(int'($urandom_range(1, 5)), 0, 1'($urandom), 1'b0);
        check("row_sat", w_t'(row2), w_t'(31));
        end_frame();

        // random frames
        for (int f = 0; f < 4; f++) begin
            thr = 8'($urandom_range(0, 255));
            frame_start();
            nl = int'($urandom_range(1, 3));
            for (int i = 0; i < nl; i++) begin
                nw = ($urandom_range(0, 3) == 0) ? 320
                                                 : int'($urandom_range(1, 12));
                do_line(nw, 0, 1'($urandom),
                        (i == nl - 1) && (f % 2 == 0));
            end
            if (f % 2 != 0) end_frame();
        end

        repeat (3) @(negedge clk);
        check("cnt_wa1", w_t'(mwa1), w_t'(ewa1));
        check("cnt_wb1", w_t'(mwb1), w_t'(ewb1));
        check("cnt_wa2", w_t'(mwa2), w_t'(ewa2));
        check("cnt_wb2", w_t'(mwb2), w_t'(ewb2));
        check("cnt_both", w_t'(both), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
